// File: rtl/md5_round_sequencer.sv
// Sequences the four MD5 rounds of one message block through an external round engine,
// chains A..D between rounds, folds the result into H0..H3 and presents the final digest.
module md5_round_sequencer #(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            blk_valid_i,
    output logic            blk_ready_o,
    input  logic            blk_first_i,
    input  logic            blk_last_i,
    input  logic [16*N-1:0] blk_m_i,
    output logic            rnd_start_o,
    output logic [1:0]      rnd_sel_o,
    output logic [N-1:0]    rnd_a_o,
    output logic [N-1:0]    rnd_b_o,
    output logic [N-1:0]    rnd_c_o,
    output logic [N-1:0]    rnd_d_o,
    output logic [16*N-1:0] rnd_m_o,
    input  logic            rnd_done_i,
    input  logic [N-1:0]    rnd_a_i,
    input  logic [N-1:0]    rnd_b_i,
    input  logic [N-1:0]    rnd_c_i,
    input  logic [N-1:0]    rnd_d_i,
    output logic            digest_valid_o,
    input  logic            digest_ready_i,
    output logic [4*N-1:0]  digest_o,
    output logic            busy_o,
    output logic            err_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [N-1:0] IV0 = N'(32'h67452301);
    localparam logic [N-1:0] IV1 = N'(32'hEFCDAB89);
    localparam logic [N-1:0] IV2 = N'(32'h98BADCFE);
    localparam logic [N-1:0] IV3 = N'(32'h10325476);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StWait,
        StFinal,
        StOut
    } state_t;

    state_t            state;
    logic [1:0]        round;
    logic [TW-1:0]     tmo;
    logic [N-1:0]      h0, h1, h2, h3;
    logic [N-1:0]      wa, wb, wc, wd;
    logic [16*N-1:0]   msg;
    logic              last;
    logic              err;
    // Held low during reset and for the first edge after release so ready is 0 in reset.
    logic              live;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= StIdle;
            round <= 2'd0;
            tmo   <= '0;
            h0    <= IV0;
            h1    <= IV1;
            h2    <= IV2;
            h3    <= IV3;
            wa    <= '0;
            wb    <= '0;
            wc    <= '0;
            wd    <= '0;
            msg   <= '0;
            last  <= 1'b0;
            err   <= 1'b0;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                StIdle: begin
                    if (blk_valid_i && blk_ready_o) begin
                        msg   <= blk_m_i;
                        round <= 2'd0;
                        last  <= blk_last_i;
                        if (blk_first_i) begin
                            h0 <= IV0;
                            h1 <= IV1;
                            h2 <= IV2;
                            h3 <= IV3;
                            wa <= IV0;
                            wb <= IV1;
                            wc <= IV2;
                            wd <= IV3;
                        end else begin
                            wa <= h0;
                            wb <= h1;
                            wc <= h2;
                            wd <= h3;
                        end
                        state <= StRun;
                    end
                end
                StRun: begin
                    tmo   <= '0;
                    state <= StWait;
                end
                StWait: begin
                    // A done arriving on the expiry cycle takes priority over the timeout.
                    if (rnd_done_i) begin
                        wa <= rnd_a_i;
                        wb <= rnd_b_i;
                        wc <= rnd_c_i;
                        wd <= rnd_d_i;
                        if (round == 2'd3) begin
                            state <= StFinal;
                        end else begin
                            round <= round + 2'd1;
                            state <= StRun;
                        end
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        tmo   <= '0;
                        state <= StIdle;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                StFinal: begin
                    h0    <= h0 + wa;
                    h1    <= h1 + wb;
                    h2    <= h2 + wc;
                    h3    <= h3 + wd;
                    state <= last ? StOut : StIdle;
                end
                StOut: begin
                    if (digest_ready_i) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign blk_ready_o    = live && (state == StIdle);
    assign rnd_start_o    = (state == StRun);
    assign rnd_sel_o      = round;
    assign rnd_a_o        = wa;
    assign rnd_b_o        = wb;
    assign rnd_c_o        = wc;
    assign rnd_d_o        = wd;
    assign rnd_m_o        = msg;
    assign digest_valid_o = (state == StOut);
    assign digest_o       = digest_valid_o ? {h0, h1, h2, h3} : '0;
    assign busy_o         = (state != StIdle);
    assign err_o          = err;

endmodule

// File: tb/tb_md5_round_sequencer.sv
// Randomized bench: a behavioural round engine answers start pulses; an MD5-level model
// predicts round inputs, start timing and the chained digest.
module tb_md5_round_sequencer;

    localparam int unsigned N   = 32;
    localparam int unsigned TMO = 8;
    localparam logic [127:0] IV = 128'h67452301_EFCDAB89_98BADCFE_10325476;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          blk_valid_i = 1'b0;
    logic          blk_ready_o;
    logic          blk_first_i = 1'b0;
    logic          blk_last_i = 1'b0;
    logic [511:0]  blk_m_i = '0;
    logic          rnd_start_o;
    logic [1:0]    rnd_sel_o;
    logic [31:0]   rnd_a_o, rnd_b_o, rnd_c_o, rnd_d_o;
    logic [511:0]  rnd_m_o;
    logic          rnd_done_i = 1'b0;
    logic [31:0]   rnd_a_i = '0, rnd_b_i = '0, rnd_c_i = '0, rnd_d_i = '0;
    logic          digest_valid_o;
    logic          digest_ready_i = 1'b0;
    logic [127:0]  digest_o;
    logic          busy_o;
    logic          err_o;

    md5_round_sequencer #(.N(N), .TIMEOUT(TMO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .blk_valid_i    (blk_valid_i),
        .blk_ready_o    (blk_ready_o),
        .blk_first_i    (blk_first_i),
        .blk_last_i     (blk_last_i),
        .blk_m_i        (blk_m_i),
        .rnd_start_o    (rnd_start_o),
        .rnd_sel_o      (rnd_sel_o),
        .rnd_a_o        (rnd_a_o),
        .rnd_b_o        (rnd_b_o),
        .rnd_c_o        (rnd_c_o),
        .rnd_d_o        (rnd_d_o),
        .rnd_m_o        (rnd_m_o),
        .rnd_done_i     (rnd_done_i),
        .rnd_a_i        (rnd_a_i),
        .rnd_b_i        (rnd_b_i),
        .rnd_c_i        (rnd_c_i),
        .rnd_d_i        (rnd_d_i),
        .digest_valid_o (digest_valid_o),
        .digest_ready_i (digest_ready_i),
        .digest_o       (digest_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // ---------------- MD5 round reference ----------------
    logic [31:0] k_tab [64];
    int          sh_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [127:0] md5_round(input int r, input logic [127:0] abcd,
                                               input logic [511:0] m);
        logic [31:0] a, b, c, d, f, t;
        int g;
        {a, b, c, d} = abcd;
        for (int j = 0; j < 16; j++) begin
            case (r)
                0: begin f = (b & c) | (~b & d); g = j;                end
                1: begin f = (d & b) | (~d & c); g = (5 * j + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * j + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * j) % 16;    end
            endcase
            t = a + f + k_tab[16 * r + j] + m[g * 32 +: 32];
            a = d;
            d = c;
            c = b;
            b = b + rotl(t, sh_tab[4 * r + (j % 4)]);
        end
        return {a, b, c, d};
    endfunction

    // mode 0: identity engine, 1: MD5 round, 2: never answers
    function automatic logic [127:0] eng(input int mode, input int r, input logic [127:0] abcd,
                                         input logic [511:0] m);
        return (mode == 1) ? md5_round(r, abcd, m) : abcd;
    endfunction

    function automatic logic [127:0] add4(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] s;
        for (int i = 0; i < 4; i++) s[i * 32 +: 32] = x[i * 32 +: 32] + y[i * 32 +: 32];
        return s;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i * 32 +: 32] = $urandom();
        return v;
    endfunction

    // ---------------- engine responder ----------------
    int           eng_mode = 0;
    int           eng_lat  = 1;
    int           eng_cnt  = 0;
    bit           spurious = 1'b0;
    logic [127:0] eng_pend;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            eng_cnt    = 0;
            rnd_done_i = 1'b0;
        end else begin
            rnd_done_i = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    rnd_done_i = 1'b1;
                    {rnd_a_i, rnd_b_i, rnd_c_i, rnd_d_i} = eng_pend;
                end
            end
            if (rnd_start_o && eng_mode != 2) begin
                eng_pend = eng(eng_mode, int'(rnd_sel_o), {rnd_a_o, rnd_b_o, rnd_c_o, rnd_d_o},
                               rnd_m_o);
                eng_cnt  = eng_lat;
            end
            if (spurious) begin
                rnd_done_i = 1'b1;
                rnd_a_i    = $urandom();
                rnd_b_i    = $urandom();
                rnd_c_i    = $urandom();
                rnd_d_i    = $urandom();
                spurious   = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int           st_cyc [$];
    logic [1:0]   st_sel [$];
    logic [127:0] st_abcd [$];
    bit           dv_seen = 1'b0;
    int           dv_cyc  = 0;

    always @(negedge clk_i) begin
        if (rnd_start_o) begin
            st_cyc.push_back(cyc);
            st_sel.push_back(rnd_sel_o);
            st_abcd.push_back({rnd_a_o, rnd_b_o, rnd_c_o, rnd_d_o});
        end
        if (digest_valid_o && !dv_seen) begin
            dv_seen = 1'b1;
            dv_cyc  = cyc;
        end
    end

    // ---------------- sequencer model and drivers ----------------
    logic [127:0] h_model = IV;
    logic [127:0] w_exp [4];
    logic [127:0] last_digest;

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic model_block(input logic [511:0] m, input bit first, input int mode);
        logic [127:0] w;
        if (first) h_model = IV;
        w = h_model;
        for (int r = 0; r < 4; r++) begin
            w_exp[r] = w;
            w = eng(mode, r, w, m);
        end
        h_model = add4(h_model, w);
    endtask

    task automatic send_block(input logic [511:0] m, input bit first, input bit last,
                              output int h);
        int n = 0;
        blk_m_i     = m;
        blk_first_i = first;
        blk_last_i  = last;
        blk_valid_i = 1'b1;
        while (!blk_ready_o && n < 60) begin
            tick();
            n++;
        end
        check_eq("accept ready", blk_ready_o, 1);
        st_cyc.delete();
        st_sel.delete();
        st_abcd.delete();
        dv_seen = 1'b0;
        h = cyc;
        tick();
        blk_valid_i = 1'b0;
        check_eq("msg latched", rnd_m_o, m);
        check_eq("busy in run", busy_o, 1);
    endtask

    task automatic wait_block(input bit last, input int lat, input int h);
        int n = 0;
        int budget = 4 * (lat + 1) + 12;
        while (!(last ? digest_valid_o : blk_ready_o) && n < budget) begin
            tick();
            n++;
        end
        check_eq("block end", last ? digest_valid_o : blk_ready_o, 1);
        check_eq("start count", st_cyc.size(), 4);
        for (int k = 0; k < 4 && k < st_cyc.size(); k++) begin
            check_eq($sformatf("sel%0d", k), st_sel[k], k);
            check_eq($sformatf("start cyc%0d", k), st_cyc[k], h + 1 + k * (lat + 1));
            check_eq($sformatf("round in%0d", k), st_abcd[k], w_exp[k]);
        end
        if (last) check_eq("digest cycle", dv_cyc, h + 4 * lat + 6);
        else      check_eq("no digest", dv_seen, 0);
    endtask

    task automatic out_phase(input logic [127:0] exp, input int hold, input bit spur);
        digest_ready_i = 1'b0;
        if (hold > 0) begin
            blk_m_i     = rand512();
            blk_first_i = 1'b1;
            blk_last_i  = 1'b1;
            blk_valid_i = 1'b1;
            spurious    = spur;
        end
        st_cyc.delete();
        for (int i = 0; i < hold; i++) begin
            check_eq("held digest", digest_o, exp);
            check_eq("ready in out", blk_ready_o, 0);
            tick();
        end
        check_eq("no start in out", st_cyc.size(), 0);
        blk_valid_i    = 1'b0;
        digest_ready_i = 1'b1;
        check_eq("digest", digest_o, exp);
        check_eq("digest valid", digest_valid_o, 1);
        last_digest = digest_o;
        tick();
        digest_ready_i = 1'b0;
        check_eq("out released", {digest_valid_o, busy_o, blk_ready_o}, 3'b001);
    endtask

    task automatic run_msg(input int nblk, input int lat, input int mode, input int hold,
                           input bit spur, input bit cont, input bit fixed,
                           input logic [511:0] m0);
        int h;
        logic [511:0] m;
        bit first, last;
        eng_mode = mode;
        eng_lat  = lat;
        for (int b = 0; b < nblk; b++) begin
            m     = (fixed && b == 0) ? m0 : rand512();
            first = (b == 0) && !cont;
            last  = (b == nblk - 1);
            model_block(m, first, mode);
            send_block(m, first, last, h);
            wait_block(last, lat, h);
            if (last) out_phase(h_model, hold, spur);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [511:0] m0;
        int h, s, n;
        for (int i = 0; i < 64; i++) begin
            real x;
            x = $sin(real'(i + 1));
            if (x < 0.0) x = -x;
            k_tab[i] = 32'(longint'($floor(x * 4294967296.0)));
        end

        repeat (2) tick();
        check_eq("reset ctl", {blk_ready_o, rnd_start_o, rnd_sel_o, busy_o, err_o,
                               digest_valid_o}, 0);
        check_eq("reset data", {rnd_a_o, rnd_b_o, rnd_c_o, rnd_d_o, digest_o}, 0);
        check_eq("reset msg", rnd_m_o, 0);
        rst_i = 1'b1;
        tick();
        check_eq("ready after reset", {blk_ready_o, busy_o, err_o}, 3'b100);

        run_msg(1, 1, 0, 0, 0, 0, 0, '0);
        check_eq("identity 1 block", last_digest,
                 128'hCE8A4602_DF9B5712_3175B9FC_2064A8EC);

        run_msg(2, 1, 0, 0, 0, 0, 0, '0);
        check_eq("identity 2 blocks", last_digest,
                 128'h9D148C04_BF36AE24_62EB73F8_40C951D8);

        m0 = '0;
        m0[31:0] = 32'h00000080;
        run_msg(1, 2, 1, 0, 0, 0, 1, m0);
        check_eq("md5 empty", last_digest, 128'hD98C1DD4_04B2008F_980980E9_7E42F8EC);

        // Digest held off with a block offered and a stray done.
        run_msg(1, 3, 1, 5, 1, 0, 0, '0);

        // Done lands on the cycle the timeout would expire.
        run_msg(1, TMO, 1, 1, 0, 0, 0, '0);
        check_eq("done beats timeout", err_o, 0);

        repeat (8) begin
            run_msg($urandom_range(1, 3), $urandom_range(1, TMO), $urandom_range(0, 1),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0, '0);
        end
        check_eq("no error yet", err_o, 0);

        // Engine that never answers.
        eng_mode = 2;
        send_block(rand512(), 1, 1, h);
        h_model = IV;
        s = h + 1;
        while (cyc < s + 8) tick();
        check_eq("err before expiry", {err_o, busy_o}, 2'b01);
        tick();
        check_eq("err after expiry", {err_o, busy_o, blk_ready_o}, 3'b101);
        repeat (3) tick();
        check_eq("no restart", st_cyc.size(), 1);
        run_msg(1, 1, 0, 0, 0, 1, 0, '0);
        check_eq("H kept after timeout", last_digest,
                 128'hCE8A4602_DF9B5712_3175B9FC_2064A8EC);
        check_eq("err sticky", err_o, 1);

        // Reset during round 2 of the second block of a message.
        eng_mode = 1;
        eng_lat  = 3;
        m0 = rand512();
        model_block(m0, 1, 1);
        send_block(m0, 1, 0, h);
        wait_block(0, 3, h);
        m0 = rand512();
        model_block(m0, 0, 1);
        send_block(m0, 0, 1, h);
        n = 0;
        while (st_cyc.size() < 3 && n < 40) begin
            tick();
            n++;
        end
        check_eq("reach round 2", st_cyc.size(), 3);
        tick();
        #2 rst_i = 1'b0;
        #1;
        check_eq("async reset ctl", {blk_ready_o, rnd_start_o, rnd_sel_o, busy_o, err_o,
                                     digest_valid_o}, 0);
        check_eq("async reset data", {rnd_a_o, rnd_b_o, rnd_c_o, rnd_d_o, digest_o}, 0);
        check_eq("async reset msg", rnd_m_o, 0);
        repeat (2) tick();
        rst_i   = 1'b1;
        h_model = IV;
        dv_seen = 1'b0;
        repeat (2) tick();
        check_eq("no digest after reset", dv_seen, 0);
        run_msg(1, 1, 0, 0, 0, 1, 0, '0);
        check_eq("H is IV after reset", last_digest,
                 128'hCE8A4602_DF9B5712_3175B9FC_2064A8EC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md5_round_sequencer.md
Name: md5_round_sequencer

Overview:
- Controller that sequences the per-round MD5 compression engine (one round = 16 steps, round index 0..3) over one 512-bit message block.
- Accepts message blocks over a valid/ready handshake and holds the 16 message words stable for the engine.
- Issues four round commands, chaining A..D between rounds, and adds the result into the chaining state H0..H3.
- Presents the 128-bit digest after the last block of a message. Sits between the message padder and the round engine.

Parameters:
- N, 32, word width (MD5 uses 32).
- TIMEOUT, 64, max cycles to wait for rnd_done_i after rnd_start_o before an error is declared.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-low.
- blk_valid_i  in  1  message block offered.
- blk_ready_o  out  1  sequencer can accept a block.
- blk_first_i  in  1  block is the first of a message; H is initialised from IV.
- blk_last_i  in  1  block is the last of a message; digest is emitted after it.
- blk_m_i  in  16xN  message words M[0..15], little-endian words.
- rnd_start_o  out  1  one-cycle command pulse to the round engine.
- rnd_sel_o  out  2  round index 0..3 for the current command.
- rnd_a_o, rnd_b_o, rnd_c_o, rnd_d_o  out  N each  working variables into the engine.
- rnd_m_o  out  16xN  latched message words, stable from block accept until FINAL.
- rnd_done_i  in  1  engine finished the round; results are valid this cycle.
- rnd_a_i, rnd_b_i, rnd_c_i, rnd_d_i  in  N each  engine results.
- digest_valid_o  out  1  digest available.
- digest_ready_i  in  1  digest consumer accepts.
- digest_o  out  4N  {H0,H1,H2,H3}, H0 in the MSBs, no byte swap.
- busy_o  out  1  state is not IDLE.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state IDLE; round counter 0; timeout counter 0.
  - H0..H3 = 67452301, EFCDAB89, 98BADCFE, 10325476 (hex).
  - Working registers and message registers 0.
  - All outputs 0 except blk_ready_o=1 after reset is released.
- States: IDLE, RUN, WAIT, FINAL, OUT.
- IDLE:
  - blk_ready_o=1. On blk_valid_i&blk_ready_o, latch blk_m_i into the message registers and set round=0.
  - Working A..D are loaded from IV if blk_first_i=1, else from the current H. If blk_first_i=1, H is also reloaded with IV.
  - Latch blk_last_i. Next state is RUN.
- RUN: rnd_start_o=1 for exactly one cycle, with rnd_sel_o=round and rnd_a..d_o=working registers. Clear the timeout counter. Next state is WAIT.
- WAIT:
  - rnd_sel_o and rnd_a..d_o are held.
  - On rnd_done_i: capture rnd_a..d_i into the working registers. If round==3, go to FINAL; otherwise round+1 and go to RUN.
  - Without rnd_done_i, the timeout counter increments. When it reaches TIMEOUT: set err_o, go to IDLE, leave H unchanged, and drop the block.
- FINAL (one cycle): Hk = Hk + working_k mod 2^N, carries discarded. Go to OUT if the latched last flag is set, else go to IDLE.
- OUT:
  - digest_valid_o=1 and digest_o stable until digest_ready_i=1. That handshake cycle is the last cycle of OUT; next state is IDLE.
  - blk_ready_o=0 throughout OUT, so the next message cannot overwrite H early.
- Latency: with an engine asserting done L cycles after start (L>=1), handshake at cycle 0 gives:
  - round k start at cycle 1+k(L+1);
  - FINAL at cycle 4L+5;
  - digest_valid_o at cycle 4L+6.
- Ignored or corner inputs:
  - rnd_done_i outside WAIT is ignored.
  - blk_valid_i outside IDLE is ignored, and blk_ready_o=0 there.
  - rnd_done_i in the same cycle that the timeout expires: done wins, and err_o is not set.
- err_o is cleared only by reset. The sequencer keeps accepting blocks after an error.
- Reset asserted mid-operation returns to the reset state immediately. The partial block is lost and no digest is emitted.
- busy_o=1 in RUN, WAIT, FINAL and OUT.

Test Plan:
- Identity engine (done 1 cycle after start, returns inputs): single block, first=last=1 -> digest_o = CE8A4602_DF9B5712_3175B9FC_2064A8EC; digest_valid_o rises at cycle 10; exactly 4 start pulses with rnd_sel_o = 0,1,2,3.
- Identity engine, two blocks (first=1/last=0, then first=0/last=1) -> no digest after block 1; after block 2, digest_o = 9D148C04_BF36AE24_62EB73F8_40C951D8.
- Behavioural MD5 round model, padded empty message (M[0]=00000080, M[14]=0, others 0) -> digest_o = D98C1DD4_04B2008F_980980E9_7E42F8EC.
- Engine never asserts done, TIMEOUT=8 -> err_o=1 nine cycles after the start pulse, state IDLE, blk_ready_o=1, H equal to IV.
- digest_ready_i held 0 for 5 cycles with blk_valid_i=1 and a spurious rnd_done_i -> digest_o stable, blk_ready_o=0, no start pulse; completes on the cycle digest_ready_i=1.
- rst_i pulsed low during round 2 WAIT -> all outputs 0 asynchronously; H=IV after release; the next block starts cleanly at round 0.
